// File: rtl/sr_flip_flop.sv
// Clocked SR flip-flop with a selectable response to the S=R=1 condition.
// Q, Qbar and INVALID all come from registers. Qbar is the inverse of the
// same register as Q, so the two can never be skewed by a cycle.
module sr_flip_flop #(
  parameter logic RESET_VAL    = 1'b0,
  parameter int   INVALID_MODE = 0
) (
  input  logic CLK,
  input  logic RST,
  input  logic S,
  input  logic R,
  output logic Q,
  output logic Qbar,
  output logic INVALID
);

  logic q_p0;
  logic invalid_p0;
  logic q_next;
  logic invalid_next;

  // Action taken when S and R are both requested.
  // Unknown mode values fall back to hold.
  function automatic logic invalid_action(input logic q_cur);
    logic res;
    case (INVALID_MODE)
      1:       res = ~q_cur;
      2:       res = 1'b0;
      3:       res = 1'b1;
      default: res = q_cur;
    endcase
    return res;
  endfunction

  // Next-state decode from the S/R request pair.
  always_comb begin
    q_next       = q_p0;
    invalid_next = S & R;
    case ({S, R})
      2'b10:   q_next = 1'b1;
      2'b01:   q_next = 1'b0;
      2'b11:   q_next = invalid_action(q_p0);
      default: q_next = q_p0;
    endcase
  end

  // State register; reset overrides every S/R combination.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_p0       <= RESET_VAL;
      invalid_p0 <= 1'b0;
    end else begin
      q_p0       <= q_next;
      invalid_p0 <= invalid_next;
    end
  end

  // Both outputs are driven straight from the register.
  assign Q       = q_p0;
  assign Qbar    = ~q_p0;
  assign INVALID = invalid_p0;

endmodule

// File: tb/tb_sr_flip_flop.sv
// Self-checking bench for sr_flip_flop. Five instances share the inputs:
// modes 0..3 with RESET_VAL=0, plus an out-of-range mode (5) with RESET_VAL=1.
module tb_sr_flip_flop;

  localparam int N = 5;

  logic CLK;
  logic RST;
  logic S;
  logic R;
  logic q_o   [N];
  logic qb_o  [N];
  logic inv_o [N];

  // Model state, one entry per instance
  logic mq   [N];
  logic minv [N];

  int total;
  int bad;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int   MODE = (g == 4) ? 5 : g;
    localparam logic RV   = (g == 4) ? 1'b1 : 1'b0;
    sr_flip_flop #(.RESET_VAL(RV), .INVALID_MODE(MODE)) dut (
      .CLK(CLK), .RST(RST), .S(S), .R(R),
      .Q(q_o[g]), .Qbar(qb_o[g]), .INVALID(inv_o[g])
    );
  end

  // 20 ns period, clock starts high
  initial begin
    CLK = 1'b1;
    forever #10 CLK = ~CLK;
  end

  function automatic int mode_of(input int i);
    return (i == 4) ? 5 : i;
  endfunction

  function automatic logic rv_of(input int i);
    return (i == 4) ? 1'b1 : 1'b0;
  endfunction

  // Behavioural reference: apply the sampled request to every instance.
  task automatic model_edge(input logic s, input logic r, input logic rst);
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        mq[i]   = rv_of(i);
        minv[i] = 1'b0;
      end else begin
        minv[i] = s && r;
        if (s && !r)      mq[i] = 1'b1;
        else if (!s && r) mq[i] = 1'b0;
        else if (s && r) begin
          if (mode_of(i) == 1)      mq[i] = (mq[i] === 1'b1) ? 1'b0 : (mq[i] === 1'b0) ? 1'b1 : 1'bx;
          else if (mode_of(i) == 2) mq[i] = 1'b0;
          else if (mode_of(i) == 3) mq[i] = 1'b1;
        end
      end
    end
  endtask

  // Drive on the falling edge, let one rising edge sample it, settle 1 ns.
  task automatic drive_edge(input logic s, input logic r, input logic rst);
    @(negedge CLK);
    S = s; R = r; RST = rst;
    @(posedge CLK);
    #1;
    model_edge(s, r, rst);
  endtask

  task automatic test_reset();
    drive_edge(1'b1, 1'b0, 1'b1);
    drive_edge(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) begin
      total++;
      if (q_o[i] !== mq[i] || qb_o[i] !== ~mq[i] || inv_o[i] !== minv[i]) begin
        bad++;
        $display("FAIL reset dut%0d got Q=%b Qbar=%b INVALID=%b want Q=%b Qbar=%b INVALID=%b",
                 i, q_o[i], qb_o[i], inv_o[i], mq[i], ~mq[i], minv[i]);
      end
    end
  endtask

  task automatic test_set_clear();
    logic sv [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic rv [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      drive_edge(sv[k], rv[k], 1'b0);
      for (int i = 0; i < N; i++) begin
        total++;
        if (q_o[i] !== mq[i] || qb_o[i] !== ~mq[i] || inv_o[i] !== minv[i]) begin
          bad++;
          $display("FAIL set_clear step%0d dut%0d got Q=%b Qbar=%b INVALID=%b want Q=%b Qbar=%b INVALID=%b",
                   k, i, q_o[i], qb_o[i], inv_o[i], mq[i], ~mq[i], minv[i]);
        end
      end
    end
  endtask

  task automatic test_hold(input logic level);
    drive_edge(level, ~level, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive_edge(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < N; i++) begin
        total++;
        if (q_o[i] !== level || q_o[i] !== mq[i] || qb_o[i] !== ~mq[i] || inv_o[i] !== 1'b0) begin
          bad++;
          $display("FAIL hold%0b edge%0d dut%0d got Q=%b Qbar=%b INVALID=%b want Q=%b Qbar=%b INVALID=0",
                   level, k, i, q_o[i], qb_o[i], inv_o[i], mq[i], ~mq[i]);
        end
      end
    end
  endtask

  // From Q=0: S=R=1 for four edges, then S=1,R=0 to release INVALID.
  task automatic test_invalid();
    drive_edge(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive_edge(1'b1, 1'b1, 1'b0);
      else       drive_edge(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < N; i++) begin
        total++;
        if (q_o[i] !== mq[i] || qb_o[i] !== ~mq[i] || inv_o[i] !== minv[i]) begin
          bad++;
          $display("FAIL invalid edge%0d dut%0d got Q=%b Qbar=%b INVALID=%b want Q=%b Qbar=%b INVALID=%b",
                   k, i, q_o[i], qb_o[i], inv_o[i], mq[i], ~mq[i], minv[i]);
        end
      end
      // Toggle-mode instance must alternate 1,0,1,0
      if (k < 4) begin
        total++;
        if (q_o[1] !== ((k % 2 == 0) ? 1'b1 : 1'b0)) begin
          bad++;
          $display("FAIL toggle_seq edge%0d got Q=%b want %b", k, q_o[1], (k % 2 == 0) ? 1'b1 : 1'b0);
        end
      end
    end
  endtask

  // Glitches on S, R and RST between edges, and falling edges, change nothing.
  task automatic test_between_edges();
    drive_edge(1'b0, 1'b1, 1'b0);
    @(negedge CLK);
    #1;
    S = 1'b1; #2; S = 1'b0; #1;
    R = 1'b0; #1;
    RST = 1'b1; #2; RST = 1'b0;
    S = 1'b1; R = 1'b1; #1;
    for (int i = 0; i < N; i++) begin
      total++;
      if (q_o[i] !== mq[i] || qb_o[i] !== ~mq[i] || inv_o[i] !== minv[i]) begin
        bad++;
        $display("FAIL mid_cycle dut%0d got Q=%b Qbar=%b INVALID=%b want Q=%b Qbar=%b INVALID=%b",
                 i, q_o[i], qb_o[i], inv_o[i], mq[i], ~mq[i], minv[i]);
      end
    end
    S = 1'b0; R = 1'b0;
    @(posedge CLK);
    #1;
    model_edge(1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    #1;
    for (int i = 0; i < N; i++) begin
      total++;
      if (q_o[i] !== mq[i] || qb_o[i] !== ~mq[i] || inv_o[i] !== minv[i]) begin
        bad++;
        $display("FAIL glitch dut%0d got Q=%b Qbar=%b INVALID=%b want Q=%b Qbar=%b INVALID=%b",
                 i, q_o[i], qb_o[i], inv_o[i], mq[i], ~mq[i], minv[i]);
      end
    end
  endtask

  // RST beats S=R=1; release then a normal set on the next edge.
  task automatic test_reset_priority();
    drive_edge(1'b1, 1'b0, 1'b0);
    drive_edge(1'b1, 1'b1, 1'b0);
    drive_edge(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < N; i++) begin
      total++;
      if (q_o[i] !== rv_of(i) || qb_o[i] !== ~rv_of(i) || inv_o[i] !== 1'b0) begin
        bad++;
        $display("FAIL rst_priority dut%0d got Q=%b Qbar=%b INVALID=%b want Q=%b Qbar=%b INVALID=0",
                 i, q_o[i], qb_o[i], inv_o[i], rv_of(i), ~rv_of(i));
      end
    end
    drive_edge(1'b0, 1'b1, 1'b0);
    drive_edge(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      total++;
      if (q_o[i] !== 1'b1 || qb_o[i] !== 1'b0 || inv_o[i] !== minv[i]) begin
        bad++;
        $display("FAIL rst_release dut%0d got Q=%b Qbar=%b INVALID=%b want Q=1 Qbar=0 INVALID=%b",
                 i, q_o[i], qb_o[i], inv_o[i], minv[i]);
      end
    end
  endtask

  task automatic test_random();
    logic s, r, rst;
    for (int k = 0; k < 400; k++) begin
      s   = 1'($urandom_range(0, 1));
      r   = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 15) == 0);
      drive_edge(s, r, rst);
      for (int i = 0; i < N; i++) begin
        total++;
        if (q_o[i] !== mq[i] || qb_o[i] !== ~mq[i] || inv_o[i] !== minv[i]) begin
          bad++;
          $display("FAIL random cyc%0d dut%0d S=%b R=%b RST=%b got Q=%b Qbar=%b INVALID=%b want Q=%b Qbar=%b INVALID=%b",
                   k, i, s, r, rst, q_o[i], qb_o[i], inv_o[i], mq[i], ~mq[i], minv[i]);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RST = 1'b1;
    S   = 1'b1;
    R   = 1'b0;
    for (int i = 0; i < N; i++) begin
      mq[i]   = 1'bx;
      minv[i] = 1'bx;
    end
    test_reset();
    test_set_clear();
    test_hold(1'b0);
    test_hold(1'b1);
    test_invalid();
    test_between_edges();
    test_reset_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sr_flip_flop.md
SR_FLIP_FLOP -- requirements
Module: sr_flip_flop

Interface
REQ-001 The block SHALL have one clock and one reset; the reset is synchronous and active-high.
REQ-002 Parameter RESET_VAL, default 1'b0: the value Q SHALL take on reset.
REQ-003 Parameter INVALID_MODE, default 0: the response to S=R=1 (0 = hold, 1 = toggle, 2 = force 0, 3 = force 1); any other value SHALL behave as 0.
REQ-004 Port CLK  input  1  clock; all state changes SHALL occur on the rising edge only.
REQ-005 Port RST  input  1  synchronous active-high reset, sampled on the rising CLK edge.
REQ-006 Port S  input  1  set request, sampled on the rising CLK edge.
REQ-007 Port R  input  1  reset (clear) request, sampled on the rising CLK edge.
REQ-008 Port Q  output  1  registered flip-flop state.
REQ-009 Port Qbar  output  1  complement of Q.
REQ-010 Port INVALID  output  1  registered flag, high for the cycle after S=R=1 was sampled.

Function
REQ-011 At each rising CLK edge with RST=0, Q SHALL update per the sampled S and R:
- S=0, R=0: Q holds.
- S=1, R=0: Q <= 1.
- S=0, R=1: Q <= 0.
- S=1, R=1: Q follows INVALID_MODE.
REQ-012 Latency SHALL be one clock: Q reflects the S/R sampled at edge n immediately after edge n; no combinational path SHALL exist from S or R to Q, Qbar or INVALID.
REQ-013 Qbar SHALL equal ~Q at all times, including after reset and during S=R=1, with no cycle of skew.
REQ-014 INVALID SHALL be 1 after an edge that sampled S=R=1 with RST=0, and 0 after every other edge.
REQ-015 S and R changes between rising edges SHALL have no effect; falling edges SHALL cause no change.
REQ-016 S=R=1 held for N consecutive edges SHALL apply the INVALID_MODE action at every edge (mode 1 toggles Q at each edge) and keep INVALID=1 throughout.
REQ-017 Before the first reset edge, Q SHALL be X in simulation; an initial value is not required.

Reset
REQ-018 RST=1 at a rising edge SHALL set Q=RESET_VAL, Qbar=~RESET_VAL and INVALID=0, regardless of S and R.
REQ-019 RST SHALL have priority over S=R=1 and over every other S/R combination.
REQ-020 RST asserted between edges SHALL have no effect until the next rising edge.
REQ-021 Reset released at edge n SHALL let the S/R sampled at edge n+1 take effect normally.
REQ-022 Reset asserted mid-operation SHALL discard the prior state; no history SHALL survive reset.

Verification
REQ-023 Bench SHALL cover: RST=1 for 2 edges with S=1, R=0 -> Q=0, Qbar=1, INVALID=0 (RESET_VAL=0).
REQ-024 Bench SHALL cover: RST=0, S=1, R=0 for 50 ns with a 20 ns CLK period starting high -> Q=1, Qbar=0 after the first rising edge; S=0, R=1 -> Q=0, Qbar=1 at the next edge.
REQ-025 Bench SHALL cover: S=0, R=0 after Q=0 -> Q stays 0 across 3 edges; after Q=1 -> Q stays 1.
REQ-026 Bench SHALL cover: S=1, R=1 with INVALID_MODE=0 and Q=0 -> Q stays 0, INVALID=1 one cycle later; then S=1, R=0 -> Q=1, INVALID=0.
REQ-027 Bench SHALL cover: INVALID_MODE=1 with S=R=1 for 4 edges from Q=0 -> Q sequence 1,0,1,0, Qbar always its complement.
REQ-028 Bench SHALL cover: S toggled high then low between two rising edges -> Q unchanged; RST=1 together with S=R=1 -> Q=RESET_VAL, INVALID=0.
